// File: rtl/xtea_host_if.sv
// Bundle of upstream request, downstream result, engine request/response and status
// signals for the XTEA host; slave is the host side, master is the environment side.
interface xtea_host_if #(
  parameter int CNT_W = 16
);
  logic             s_valid_i;
  logic             s_ready_o;
  logic [63:0]      s_data_i;
  logic [127:0]     s_key_i;
  logic             s_decrypt_i;
  logic             m_valid_o;
  logic             m_ready_i;
  logic [63:0]      m_data_o;
  logic             m_err_o;
  logic             x_valid_o;
  logic             x_en_o;
  logic [63:0]      x_data_o;
  logic [127:0]     x_key_o;
  logic             x_decrypt_o;
  logic [63:0]      x_result_i;
  logic             x_valid_i;
  logic             x_busy_i;
  logic             busy_o;
  logic [CNT_W-1:0] done_cnt_o;

  modport slave (
    input  s_valid_i, s_data_i, s_key_i, s_decrypt_i, m_ready_i,
           x_result_i, x_valid_i, x_busy_i,
    output s_ready_o, m_valid_o, m_data_o, m_err_o, x_valid_o, x_en_o,
           x_data_o, x_key_o, x_decrypt_o, busy_o, done_cnt_o
  );

  modport master (
    output s_valid_i, s_data_i, s_key_i, s_decrypt_i, m_ready_i,
           x_result_i, x_valid_i, x_busy_i,
    input  s_ready_o, m_valid_o, m_data_o, m_err_o, x_valid_o, x_en_o,
           x_data_o, x_key_o, x_decrypt_o, busy_o, done_cnt_o
  );
endinterface

// File: rtl/xtea_host.sv
// Single-request host around an XTEA engine: latches a block, strobes the engine once,
// waits for its result with a timeout, and holds the result until the consumer takes it.
module xtea_host #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input logic        clk,
  input logic        rst_ni,
  xtea_host_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  logic             ready_c, issue_c, busy_c;
  logic             accept, result_in, timeout, handshake;

  logic [63:0]      x_data_p0;
  logic [127:0]     x_key_p0;
  logic             x_dec_p0;
  logic [15:0]      tmo_p0;

  logic [63:0]      m_data_p1;
  logic             m_err_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] done_p1;

  assign accept    = ready_c && bus.s_valid_i;
  assign result_in = (state_q == WAIT) && bus.x_valid_i;
  assign timeout   = (state_q == WAIT) && !bus.x_valid_i && (tmo_p0 == 16'd0);
  assign handshake = (state_q == HOLD) && bus.m_ready_i;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    issue_c = 1'b0;
    busy_c  = 1'b1;
    case (state_q)
      IDLE: begin
        busy_c  = 1'b0;
        ready_c = !bus.x_busy_i;
        if (ready_c && bus.s_valid_i) state_d = ISSUE;
      end
      ISSUE: begin
        issue_c = 1'b1;
        state_d = WAIT;
      end
      WAIT:    if (result_in || timeout) state_d = HOLD;
      HOLD:    if (bus.m_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request stage: operands and timeout counter toward the engine
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      x_data_p0 <= '0;
      x_key_p0  <= '0;
      x_dec_p0  <= 1'b0;
      tmo_p0    <= '0;
    end else begin
      if (accept) begin
        x_data_p0 <= bus.s_data_i;
        x_key_p0  <= bus.s_key_i;
        x_dec_p0  <= bus.s_decrypt_i;
      end
      if (state_q == ISSUE)
        tmo_p0 <= TMO_LOAD;
      else if (state_q == WAIT && !bus.x_valid_i && tmo_p0 != 16'd0)
        tmo_p0 <= tmo_p0 - 16'd1;
    end
  end

  // Result stage: a real result beats a coincident timeout
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_data_p1 <= '0;
      m_err_p1  <= 1'b0;
      vld_p1    <= 1'b0;
      done_p1   <= '0;
    end else begin
      if (result_in) begin
        m_data_p1 <= bus.x_result_i;
        m_err_p1  <= 1'b0;
        vld_p1    <= 1'b1;
      end else if (timeout) begin
        m_data_p1 <= '0;
        m_err_p1  <= 1'b1;
        vld_p1    <= 1'b1;
      end else if (handshake) begin
        vld_p1    <= 1'b0;
      end
      if (handshake && !m_err_p1) done_p1 <= done_p1 + 1'b1;
    end
  end

  assign bus.s_ready_o   = ready_c;
  assign bus.x_valid_o   = issue_c;
  assign bus.x_en_o      = issue_c;
  assign bus.busy_o      = busy_c;
  assign bus.x_data_o    = x_data_p0;
  assign bus.x_key_o     = x_key_p0;
  assign bus.x_decrypt_o = x_dec_p0;
  assign bus.m_valid_o   = vld_p1;
  assign bus.m_data_o    = m_data_p1;
  assign bus.m_err_o     = m_err_p1;
  assign bus.done_cnt_o  = done_p1;

endmodule

// File: tb/tb_xtea_host.sv
// Bench for xtea_host: transaction-level XTEA engine model and result scoreboard,
// with directed reset/timeout/backpressure/wrap scenarios followed by random blocks.
module tb_xtea_host;
  localparam int TO    = 8;
  localparam int CNT_W = 2;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } res_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  xtea_host_if #(.CNT_W(CNT_W)) bus ();

  xtea_host #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  res_t q[$];
  int   mcnt = 0;
  bit   pend = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  function automatic logic [63:0] xtea(input logic [63:0] blk, input logic [127:0] key,
                                       input logic dec);
    logic [31:0] v0, v1, sum;
    logic [31:0] k [0:3];
    k[0] = key[127:96]; k[1] = key[95:64]; k[2] = key[63:32]; k[3] = key[31:0];
    v0 = blk[63:32];
    v1 = blk[31:0];
    if (!dec) begin
      sum = 32'h0;
      for (int i = 0; i < 32; i++) begin
        v0  = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]));
        sum = sum + 32'h9E3779B9;
        v1  = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]));
      end
    end else begin
      sum = 32'hC6EF3720;
      for (int i = 0; i < 32; i++) begin
        v1  = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]));
        sum = sum - 32'h9E3779B9;
        v0  = v0 - ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]));
      end
    end
    return {v0, v1};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic zero_chk(input string name);
    chk({name, "_ctrl"}, {bus.m_valid_o, bus.m_err_o, bus.x_valid_o, bus.x_en_o,
                          bus.x_decrypt_o, bus.busy_o, bus.done_cnt_o}, '0);
    chk({name, "_data"}, {bus.m_data_o, bus.x_data_o}, '0);
    chk({name, "_key"}, bus.x_key_o, '0);
  endtask

  // Every cycle: scoreboard and counter model compared on the falling edge
  task automatic neg();
    @(negedge clk);
    if (!rst_ni) begin
      q.delete();
      mcnt = 0;
      pend = 0;
      zero_chk("in_reset");
    end else begin
      if (pend) begin
        if (!q[0].err) mcnt++;
        void'(q.pop_front());
        pend = 0;
      end
      chk("done_cnt", bus.done_cnt_o, mcnt % (1 << CNT_W));
      chk("s_ready_rule", bus.s_ready_o, !bus.busy_o && !bus.x_busy_i);
      chk("x_en_eq_x_valid", bus.x_en_o, bus.x_valid_o);
      if (q.size() == 0) begin
        chk("m_valid_unexpected", bus.m_valid_o, 1'b0);
      end else if (bus.m_valid_o) begin
        chk("m_data", bus.m_data_o, q[0].data);
        chk("m_err", bus.m_err_o, q[0].err);
        pend = bus.m_ready_i;
      end
    end
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    zero_chk("async_reset");
    repeat (2) begin neg(); pos(); end
    rst_ni = 1'b1;
    neg();
    chk("ready_after_reset", bus.s_ready_o, !bus.x_busy_i);
    pos();
  endtask

  task automatic accept_block(input logic [63:0] d, input logic [127:0] k, input logic dec,
                              input int busy_cyc);
    bus.s_data_i = d; bus.s_key_i = k; bus.s_decrypt_i = dec; bus.s_valid_i = 1'b1;
    bus.x_busy_i = (busy_cyc > 0);
    for (int b = 0; b < busy_cyc; b++) begin
      neg(); chk("busy_blocks_ready", bus.s_ready_o, 1'b0); pos();
    end
    bus.x_busy_i = 1'b0;
    neg();
    chk("accept_ready", bus.s_ready_o, 1'b1);
    chk("no_early_issue", bus.x_valid_o, 1'b0);
    pos();
    bus.s_valid_i = 1'b0;
    bus.s_data_i = {$urandom, $urandom};
    bus.s_key_i = {$urandom, $urandom, $urandom, $urandom};
    bus.s_decrypt_i = ~dec;
    neg();
    chk("issue_strobe", {bus.x_valid_o, bus.x_en_o}, 2'b11);
    chk("issue_data", bus.x_data_o, d);
    chk("issue_key", bus.x_key_o, k);
    chk("issue_dec", bus.x_decrypt_o, dec);
    pos();
  endtask

  // lat = WAIT cycle (1-based) in which the engine answers; 0 = never answers
  task automatic run_block(input logic [63:0] d, input logic [127:0] k, input logic dec,
                           input int lat, input int rdly, input int busy_cyc,
                           input bit use_force, input logic [63:0] force_res, input bit press);
    logic [63:0] res;
    bit          err;
    int          n, hold;
    res  = use_force ? force_res : xtea(d, k, dec);
    err  = !(lat >= 1 && lat <= TO + 1);
    n    = err ? TO + 1 : lat;
    hold = (lat - n > rdly) ? lat - n : rdly;
    accept_block(d, k, dec, busy_cyc);
    q.push_back('{data: err ? 64'h0 : res, err: err});
    for (int c = 1; c <= n + hold + 1; c++) begin
      bus.x_valid_i  = (c == lat);
      bus.x_result_i = (c == lat) ? res : {$urandom, $urandom};
      if (c <= n)             bus.m_ready_i = 1'($urandom_range(0, 1));
      else if (c <= n + hold) bus.m_ready_i = 1'b0;
      else                    bus.m_ready_i = 1'b1;
      bus.s_valid_i = press && c > n && c <= n + hold;
      if (bus.s_valid_i) bus.s_data_i = {$urandom, $urandom};
      neg();
      chk("x_valid_single_cycle", bus.x_valid_o, 1'b0);
      chk("x_data_stable", {bus.x_data_o, bus.x_decrypt_o}, {d, dec});
      chk("x_key_stable", bus.x_key_o, k);
      if (c <= n) chk("m_valid_low_in_wait", bus.m_valid_o, 1'b0);
      else begin
        chk("m_valid_in_hold", bus.m_valid_o, 1'b1);
        if (press) chk("hold_blocks_ready", bus.s_ready_o, 1'b0);
      end
      pos();
    end
    bus.x_valid_i = 1'b0; bus.m_ready_i = 1'b0; bus.s_valid_i = 1'b0;
    neg();
    chk("m_valid_cleared", bus.m_valid_o, 1'b0);
    chk("m_data_kept", {bus.m_data_o, bus.m_err_o}, {err ? 64'h0 : res, err});
    chk("idle_after_hs", bus.busy_o, 1'b0);
    pos();
  endtask

  initial begin
    logic [63:0] ct;
    logic [1:0]  wrap_exp [0:4];
    bus.s_valid_i = 0; bus.s_data_i = 0; bus.s_key_i = 0; bus.s_decrypt_i = 0;
    bus.m_ready_i = 0; bus.x_result_i = 0; bus.x_valid_i = 0; bus.x_busy_i = 0;
    #2;
    do_reset();

    // Round trip with all-zero key
    run_block(64'h0, 128'h0, 1'b0, 5, 2, 1, 1'b0, 64'h0, 1'b0);
    neg(); chk("enc_known_answer", {bus.m_data_o, bus.m_err_o}, {64'hDEE9D4D8F7131ED9, 1'b0}); pos();
    ct = bus.m_data_o;
    run_block(ct, 128'h0, 1'b1, 3, 0, 0, 1'b0, 64'h0, 1'b0);
    neg();
    chk("dec_known_answer", {bus.m_data_o, bus.m_err_o}, {64'h0, 1'b0});
    chk("done_after_round_trip", bus.done_cnt_o, 2'd2);
    pos();

    // Engine silent, then engine answering too late (inside HOLD)
    run_block({$urandom, $urandom}, 128'h1, 1'b0, 0, 1, 0, 1'b0, 64'h0, 1'b0);
    neg();
    chk("timeout_result", {bus.m_data_o, bus.m_err_o}, {64'h0, 1'b1});
    chk("timeout_count_unchanged", bus.done_cnt_o, 2'd2);
    pos();
    run_block({$urandom, $urandom}, 128'h2, 1'b1, TO + 3, 0, 0, 1'b0, 64'h0, 1'b0);

    // Answer on the last WAIT cycle, counter at zero
    run_block(64'h55, 128'h3, 1'b0, TO + 1, 0, 0, 1'b1, 64'h1234, 1'b0);
    neg(); chk("boundary_result", {bus.m_data_o, bus.m_err_o}, {64'h1234, 1'b0}); pos();

    // Backpressure with a new request pending
    run_block({$urandom, $urandom}, {4{$urandom}}, 1'b0, 4, 20, 0, 1'b0, 64'h0, 1'b1);

    // Reset in WAIT, then a stray engine result
    accept_block(64'hABCD, 128'h7, 1'b0, 0);
    repeat (3) begin neg(); pos(); end
    #2;
    do_reset();
    bus.x_valid_i = 1'b1; bus.x_result_i = 64'hFEED;
    neg(); pos();
    bus.x_valid_i = 1'b0;
    repeat (12) begin neg(); chk("abort_no_m_valid", bus.m_valid_o, 1'b0); pos(); end

    // Counter wrap
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3; wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
    for (int i = 0; i < 5; i++) begin
      run_block({$urandom, $urandom}, {4{$urandom}}, 1'(i), 1 + i, i % 2, 0, 1'b0, 64'h0, 1'b0);
      neg(); chk("wrap_seq", bus.done_cnt_o, wrap_exp[i]); pos();
    end

    // Random blocks
    for (int i = 0; i < 25; i++) begin
      int rd;
      rd = $urandom_range(0, 3);
      run_block({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(0, 1)), $urandom_range(0, TO + 4), rd,
                $urandom_range(0, 2), 1'b0, 64'h0, (rd > 0) && ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
